// File: rtl/uart_pkg.sv
// Shared UART constants and receiver state encoding, common to the TX and RX sides.
package uart_pkg;

    localparam int DEFAULT_BAUD_DIV = 5000;
    localparam int DATA_BITS        = 8;
    localparam int CON_W            = 13;
    localparam logic STOP_LEVEL     = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } rx_state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for an asynchronous input, with a registered copy for falling-edge detection.
module uart_rx_sync (
    input  logic clk,
    input  logic res,
    input  logic rx,
    output logic rx_s,
    output logic fall
);

    logic rx_meta;
    logic rx_d;

    // Idle-high reset so a line that is already high never looks like an edge.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_d    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            rx_d    <= rx_s;
        end
    end

    assign fall = rx_d & ~rx_s;

endmodule

// File: rtl/uart_rxer_frame.sv
// 8N1 UART receiver: mid-bit sampling from a detected start edge, byte strobe and framing-error strobe.
module uart_rxer_frame
    import uart_pkg::*;
#(
    parameter int BAUD_DIV = DEFAULT_BAUD_DIV
) (
    input  logic       clk,
    input  logic       res,
    input  logic       RX,
    output logic [7:0] data_out,
    output logic       en_data_out,
    output logic       frame_err,
    output logic       busy
);

    localparam logic [CON_W-1:0] HALF_LAST = CON_W'(BAUD_DIV / 2 - 1);
    localparam logic [CON_W-1:0] FULL_LAST = CON_W'(BAUD_DIV - 1);
    localparam logic [3:0]       LAST_BIT  = 4'(DATA_BITS - 1);

    logic                 rx_s;
    logic                 fall;
    rx_state_t            state;
    logic [CON_W-1:0]     con;
    logic [3:0]           bits;
    logic [DATA_BITS-1:0] shift;

    uart_rx_sync u_sync (
        .clk  (clk),
        .res  (res),
        .rx   (RX),
        .rx_s (rx_s),
        .fall (fall)
    );

    // Data path: the shift register carries no control meaning, so it needs no reset.
    always_ff @(posedge clk) begin
        if (state == ST_DATA && con == FULL_LAST)
            shift <= {rx_s, shift[DATA_BITS-1:1]};
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state       <= ST_IDLE;
            con         <= '0;
            bits        <= '0;
            data_out    <= '0;
            en_data_out <= 1'b0;
            frame_err   <= 1'b0;
            busy        <= 1'b0;
        end else begin
            en_data_out <= 1'b0;
            frame_err   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    busy <= 1'b0;
                    if (fall) begin
                        con   <= '0;
                        busy  <= 1'b1;
                        state <= ST_START;
                    end
                end
                ST_START: begin
                    if (con == HALF_LAST) begin
                        if (!rx_s) begin
                            con   <= '0;
                            bits  <= '0;
                            state <= ST_DATA;
                        end else begin
                            busy  <= 1'b0;
                            state <= ST_IDLE;
                        end
                    end else begin
                        con <= con + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (con == FULL_LAST) begin
                        con  <= '0;
                        bits <= bits + 4'd1;
                        if (bits == LAST_BIT)
                            state <= ST_STOP;
                    end else begin
                        con <= con + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (con == FULL_LAST) begin
                        con <= '0;
                        if (rx_s == STOP_LEVEL) begin
                            data_out    <= shift;
                            en_data_out <= 1'b1;
                            busy        <= 1'b0;
                            state       <= ST_IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= ST_BREAK;
                        end
                    end else begin
                        con <= con + 1'b1;
                    end
                end
                ST_BREAK: begin
                    // A held-low line must go high before a new start edge can be seen.
                    if (rx_s) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rxer_frame.sv
// Bench for uart_rxer_frame at 16 cycles/bit: directed scenarios plus random bytes against a waveform-sampling model.
module tb_uart_rxer_frame;

    localparam int BAUD = 16;

    logic       clk;
    logic       res;
    logic       RX;
    logic [7:0] data_out;
    logic       en_data_out;
    logic       frame_err;
    logic       busy;

    int tests = 0;
    int fails = 0;

    int         cyc = 0;
    int         n_en = 0;
    int         n_ferr = 0;
    int         busy_cycles = 0;
    int         n_both = 0;
    int         n_busy_at_strobe = 0;
    int         strobe_cyc = 0;
    logic [7:0] got_q[$];

    int         fall_cyc;
    logic [7:0] exp_data;

    uart_rxer_frame #(.BAUD_DIV(BAUD)) dut (
        .clk         (clk),
        .res         (res),
        .RX          (RX),
        .data_out    (data_out),
        .en_data_out (en_data_out),
        .frame_err   (frame_err),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (en_data_out) begin
            n_en++;
            got_q.push_back(data_out);
            strobe_cyc = cyc;
            if (busy) n_busy_at_strobe++;
        end
        if (frame_err) n_ferr++;
        if (en_data_out && frame_err) n_both++;
        if (busy) busy_cycles++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, observed no finish, required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Line level of one frame driven at period p, as a function of doubled elapsed time since the start edge.
    function automatic logic frame_level(input logic [7:0] b, input int p, input logic stop, input int x2);
        int idx;
        idx = x2 / (2 * p);
        if (idx == 0) return 1'b0;
        if (idx <= 8) return b[idx-1];
        if (idx == 9) return stop;
        return 1'b1;
    endfunction

    // Pin driven half a cycle after an edge reaches the start-bit sample BAUD/2 + 0.5 cycles later;
    // later samples follow every BAUD cycles. Result: [9:8] 0=glitch 1=byte 2=framing error.
    function automatic logic [9:0] rx_expect(input logic [7:0] b, input int p, input logic stop);
        logic [7:0] got;
        int         s0;
        s0 = 1 + BAUD;
        if (frame_level(b, p, stop, s0) != 1'b0) return {2'd0, 8'h00};
        for (int k = 0; k < 8; k++)
            got[k] = frame_level(b, p, stop, s0 + 2 * BAUD * (k + 1));
        if (frame_level(b, p, stop, s0 + 2 * BAUD * 9)) return {2'd1, got};
        return {2'd2, got};
    endfunction

    task automatic send_frame(input logic [7:0] b, input int p, input logic stop);
        RX = 1'b0;
        fall_cyc = cyc;
        repeat (p) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            RX = b[i];
            repeat (p) @(negedge clk);
        end
        RX = stop;
        repeat (p) @(negedge clk);
        if (stop) RX = 1'b1;
    endtask

    task automatic settle();
        int n;
        n = 0;
        repeat (2) @(negedge clk);
        while (busy && n < 40 * BAUD) begin
            @(negedge clk);
            n++;
        end
        check("settle_idle", busy, 1'b0);
        repeat (4) @(negedge clk);
    endtask

    task automatic run_frame(input string tag, input logic [7:0] b, input int p);
        logic [9:0] e;
        int         en0;
        int         fe0;
        e   = rx_expect(b, p, 1'b1);
        en0 = n_en;
        fe0 = n_ferr;
        if (e[9:8] == 2'd1) exp_data = e[7:0];
        send_frame(b, p, 1'b1);
        settle();
        check({tag, "_strobe"}, n_en - en0, (e[9:8] == 2'd1) ? 1 : 0);
        check({tag, "_ferr"}, n_ferr - fe0, (e[9:8] == 2'd2) ? 1 : 0);
        check({tag, "_data"}, data_out, exp_data);
    endtask

    initial begin
        int         en0;
        int         fe0;
        int         bc0;
        int         base;
        int         lat;
        int         gap;
        logic [7:0] b;
        logic [9:0] e;
        logic [7:0] exp_q[$];

        res = 1'b0;
        RX  = 1'b1;
        exp_data = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_data", data_out, 8'h00);
        check("rst_en", en_data_out, 1'b0);
        check("rst_ferr", frame_err, 1'b0);
        check("rst_busy", busy, 1'b0);
        res = 1'b1;
        repeat (5) @(negedge clk);

        // Single byte with strobe latency from the pin edge (about 9.5 bit periods plus 3 cycles).
        run_frame("single_a5", 8'hA5, BAUD);
        check("single_a5_exact", data_out, 8'hA5);
        lat = strobe_cyc - fall_cyc;
        tests++;
        assert (lat >= 153 && lat <= 157) else begin
            fails++;
            $error("FAIL single_latency: observed %0d cycles expected 153..157", lat);
        end

        // Back-to-back frames as a transmitter at the same divisor would send them.
        base = got_q.size();
        en0  = n_en;
        send_frame(8'h00, BAUD, 1'b1);
        send_frame(8'hFF, BAUD, 1'b1);
        send_frame(8'h55, BAUD, 1'b1);
        settle();
        check("b2b_count", n_en - en0, 3);
        check("b2b_0", (got_q.size() > base) ? got_q[base] : 8'hxx, 8'h00);
        check("b2b_1", (got_q.size() > base + 1) ? got_q[base+1] : 8'hxx, 8'hFF);
        check("b2b_2", (got_q.size() > base + 2) ? got_q[base+2] : 8'hxx, 8'h55);
        exp_data = 8'h55;

        // Short low pulse: receiver starts, rejects at mid start bit.
        en0 = n_en;
        bc0 = busy_cycles;
        RX = 1'b0;
        repeat (4) @(negedge clk);
        RX = 1'b1;
        repeat (3 * BAUD) @(negedge clk);
        check("glitch_busy_pulsed", (busy_cycles - bc0) > 0, 1'b1);
        check("glitch_no_strobe", n_en - en0, 0);
        check("glitch_busy_low", busy, 1'b0);
        check("glitch_data", data_out, exp_data);

        // Stop bit low then line held low: one framing error, no re-trigger until high.
        en0 = n_en;
        fe0 = n_ferr;
        e = rx_expect(8'h3C, BAUD, 1'b0);
        send_frame(8'h3C, BAUD, 1'b0);
        repeat (40) @(negedge clk);
        check("ferr_model_kind", e[9:8], 2'd2);
        check("ferr_count", n_ferr - fe0, 1);
        check("ferr_no_strobe", n_en - en0, 0);
        check("ferr_held_busy", busy, 1'b1);
        check("ferr_data", data_out, exp_data);
        RX = 1'b1;
        settle();
        check("ferr_count_after", n_ferr - fe0, 1);
        run_frame("after_ferr_81", 8'h81, BAUD);

        // Sender clock off by one cycle per bit in each direction.
        run_frame("slow_96", 8'h96, 17);
        run_frame("fast_96", 8'h96, 15);

        // Random bytes with random idle gaps.
        en0  = n_en;
        base = got_q.size();
        for (int i = 0; i < 6; i++) begin
            b   = 8'($urandom);
            gap = $urandom_range(0, 12);
            e   = rx_expect(b, BAUD, 1'b1);
            if (e[9:8] == 2'd1) begin
                exp_q.push_back(e[7:0]);
                exp_data = e[7:0];
            end
            send_frame(b, BAUD, 1'b1);
            repeat (gap) @(negedge clk);
        end
        settle();
        check("rand_count", n_en - en0, exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            check($sformatf("rand_%0d", i), (got_q.size() > base + i) ? got_q[base+i] : 8'hxx, exp_q[i]);
        check("rand_last_data", data_out, exp_data);

        // Reset asserted in the middle of data bit 4 of 8'hC3.
        en0 = n_en;
        fe0 = n_ferr;
        b = 8'hC3;
        RX = 1'b0;
        repeat (BAUD) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            RX = b[i];
            repeat (BAUD) @(negedge clk);
        end
        RX = b[4];
        repeat (BAUD / 2) @(negedge clk);
        check("midrst_busy_before", busy, 1'b1);
        res = 1'b0;
        #1;
        check("midrst_data", data_out, 8'h00);
        check("midrst_en", en_data_out, 1'b0);
        check("midrst_ferr", frame_err, 1'b0);
        check("midrst_busy", busy, 1'b0);
        exp_data = 8'h00;
        @(negedge clk);
        RX = 1'b1;
        repeat (3) @(negedge clk);
        res = 1'b1;
        repeat (2 * BAUD) @(negedge clk);
        check("midrst_no_strobe", n_en - en0, 0);
        check("midrst_no_ferr", n_ferr - fe0, 0);
        run_frame("after_rst_12", 8'h12, BAUD);
        check("after_rst_12_exact", data_out, 8'h12);

        check("strobes_exclusive", n_both, 0);
        check("busy_low_at_strobe", n_busy_at_strobe, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
